stage0_fetch: RTL and testbench

//  Instruction fetch stage of the axis_cpu pipeline. Owns the PC, issues reads to a
//  1-cycle-latency synchronous instruction memory, and holds fetched instructions in a
//  2-entry buffer. Presents them to the decode stage (stage1) via vld/rdy, with a
//  per-instruction cycle count. Redirects on branch_mispredict.

---
 rtl/stage0_fetch.sv | 114 +++++++++++
 tb/tb_stage0_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage0_fetch.sv
// Instruction fetch stage: owns the PC and issues reads to a 1-cycle synchronous imem.
// Returned words are queued in a 2-entry FIFO and presented to decode with a per-entry age count.
module stage0_fetch #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 8,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_rd_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   branch_mispredict,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   PC_en,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [COUNT_WIDTH-1:0] ocount,
  output logic                   vld,
  input  logic                   next_rdy
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] data;
    logic [COUNT_WIDTH-1:0] cnt;
  } entry_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                run_q;
  logic                infl_q, infl_d;
  logic [1:0]          occ_q, occ_d;
  entry_t              fifo_q [2];
  entry_t              fifo_d [2];

  logic       pop;
  logic       issue;
  logic [2:0] pending;
  logic [1:0] survivors;
  entry_t     fresh;

  function automatic entry_t age(input entry_t e);
    entry_t r;
    r = e;
    if (e.cnt != CNT_MAX) r.cnt = e.cnt + 1'b1;
    return r;
  endfunction

  assign vld     = (occ_q != 2'd0);
  assign pop     = vld && next_rdy;
  assign pending = {1'b0, occ_q} + {2'b00, infl_q};
  // run_q holds off the first read until the first edge after reset release.
  assign issue   = run_q && !branch_mispredict && (pending < (3'd2 + {2'b00, pop}));

  assign imem_rd_en = issue;
  assign PC_en      = issue;
  assign imem_addr  = pc_q;
  assign instr_out  = vld ? fifo_q[0].data : '0;
  assign ocount     = vld ? fifo_q[0].cnt  : '0;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d       = pc_q;
    infl_d     = infl_q;
    occ_d      = occ_q;
    fifo_d     = fifo_q;
    survivors  = occ_q;
    fresh.data = imem_rdata;
    fresh.cnt  = CNT_ONE;

    if (branch_mispredict) begin
      // A killed in-flight read simply has nowhere to land once infl drops.
      pc_d   = branch_target;
      infl_d = 1'b0;
      occ_d  = 2'd0;
    end else begin
      if (issue) pc_d = pc_q + 1'b1;
      infl_d    = issue;
      survivors = occ_q - {1'b0, pop};
      fifo_d[0] = age(pop ? fifo_q[1] : fifo_q[0]);
      fifo_d[1] = age(fifo_q[1]);
      if (infl_q) begin
        if (survivors == 2'd0) fifo_d[0] = fresh;
        else                   fifo_d[1] = fresh;
      end
      occ_d = survivors + {1'b0, infl_q};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      run_q  <= 1'b0;
      infl_q <= 1'b0;
      occ_q  <= 2'd0;
      // NOTE: the FIFO is two flop entries, not RAM, so it is cheap to reset and keeps outputs deterministic.
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      pc_q   <= pc_d;
      run_q  <= 1'b1;
      infl_q <= infl_d;
      occ_q  <= occ_d;
      fifo_q <= fifo_d;
    end
  end

  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n) pending <= 3'd2);
  a_no_issue_on_flush: assert property (@(posedge clk) disable iff (!rst_n)
                                        !(imem_rd_en && branch_mispredict));

endmodule

// File: tb/tb_stage0_fetch.sv
// Bench for stage0_fetch: imem model plus an in-order scoreboard of expected instructions,
// with directed checks on latency, backpressure, flush, PC wrap, count saturation and reset.
module tb_stage0_fetch;

  localparam int PW = 10;
  localparam int IW = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] imem_addr;
  logic          imem_rd_en;
  logic [IW-1:0] imem_rdata;
  logic          branch_mispredict;
  logic [PW-1:0] branch_target;
  logic          PC_en;
  logic [IW-1:0] instr_out;
  logic [CW-1:0] ocount;
  logic          vld;
  logic          next_rdy;

  stage0_fetch #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_addr         (imem_addr),
    .imem_rd_en        (imem_rd_en),
    .imem_rdata        (imem_rdata),
    .branch_mispredict (branch_mispredict),
    .branch_target     (branch_target),
    .PC_en             (PC_en),
    .instr_out         (instr_out),
    .ocount            (ocount),
    .vld               (vld),
    .next_rdy          (next_rdy)
  );

  always #5 clk = ~clk;

  // Identity for addresses below 0x100, folded above so 0x100-page words differ from page 0.
  function automatic logic [IW-1:0] imem_f(input logic [PW-1:0] a);
    return a[7:0] ^ {4{a[9:8]}};
  endfunction

  // Synchronous imem; unrequested cycles return noise so stale captures show up.
  always @(posedge clk) imem_rdata <= imem_rd_en ? imem_f(imem_addr) : IW'($urandom);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected words pushed at issue, popped at handshake.
  logic [IW-1:0] sb [$];
  logic [PW-1:0] exp_pc = '0;
  logic [8:0]    sb_exp;
  bit            mon_on = 1'b0;
  int            rst_pulses = 0;
  int            rst_seen = 0;

  always @(negedge clk) begin
    if (rst_pulses != rst_seen) begin
      rst_seen = rst_pulses;
      sb.delete();
      exp_pc = '0;
    end
    if (mon_on && rst_n) begin
      if (branch_mispredict) begin
        check("no_issue_on_flush", imem_rd_en, 0);
        sb.delete();
        exp_pc = branch_target;
      end else begin
        if (vld && next_rdy) begin
          if (sb.size() != 0) sb_exp = {1'b0, sb.pop_front()};
          else                sb_exp = 9'h1FF;
          check("sb_instr", {1'b0, instr_out}, sb_exp);
        end
        if (imem_rd_en) begin
          check("sb_addr", imem_addr, exp_pc);
          sb.push_back(imem_f(exp_pc));
          exp_pc = exp_pc + 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    next_rdy = 1'b1;
    branch_mispredict = 1'b0;
    branch_target = '0;
    repeat (2) tick();

    check("rst_vld", vld, 0);
    check("rst_rd_en", imem_rd_en, 0);
    check("rst_pc_en", PC_en, 0);
    check("rst_instr", instr_out, 0);
    check("rst_ocount", ocount, 0);

    // 1: fetch from 0, first valid two cycles after the first read.
    rst_n = 1'b1;
    mon_on = 1'b1;
    tick();
    check("t1_rd_en", imem_rd_en, 1);
    check("t1_addr0", imem_addr, 0);
    check("t1_pc_en", PC_en, 1);
    check("t1_vld_c0", vld, 0);
    tick();
    check("t1_vld_c1", vld, 0);
    check("t1_addr1", imem_addr, 1);
    tick();
    check("t1_vld_c2", vld, 1);
    check("t1_instr0", instr_out, 0);
    check("t1_ocount", ocount, 1);
    repeat (3) tick();
    check("t2_head3", instr_out, 3);

    // 2: stall on instruction 3 for five cycles.
    next_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("t2_hold", instr_out, 3);
      check("t2_ocount", ocount, k);
      check("t2_no_issue", imem_rd_en, 0);
      tick();
    end
    check("t2_ocount6", ocount, 6);
    check("t2_vld", vld, 1);
    next_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_no_gap", vld, 1);
      tick();
    end

    // 3: flush while the buffer is full.
    next_rdy = 1'b0;
    repeat (3) tick();
    check("t3_full_no_issue", imem_rd_en, 0);
    check("t3_full_vld", vld, 1);
    branch_mispredict = 1'b1;
    branch_target = 10'h100;
    next_rdy = 1'b1;
    #1;
    check("t3_rd_en_masked", imem_rd_en, 0);
    tick();
    branch_mispredict = 1'b0;
    #1;
    check("t3_vld_cleared", vld, 0);
    check("t3_rd_en", imem_rd_en, 1);
    check("t3_addr", imem_addr, 10'h100);
    tick();
    check("t3_vld_c1", vld, 0);
    tick();
    check("t3_vld_c2", vld, 1);
    check("t3_instr", instr_out, imem_f(10'h100));

    // 4: back-to-back mispredicts, last target wins, PC wraps.
    repeat (3) tick();
    branch_mispredict = 1'b1;
    branch_target = 10'h055;
    tick();
    branch_target = 10'h3FE;
    tick();
    branch_mispredict = 1'b0;
    #1;
    check("t4_addr_3fe", imem_addr, 10'h3FE);
    tick();
    check("t4_addr_3ff", imem_addr, 10'h3FF);
    tick();
    check("t4_addr_wrap", imem_addr, 10'h000);
    check("t4_rd_en_wrap", imem_rd_en, 1);

    // 5: long stall, count saturates.
    repeat (4) tick();
    check("t5_steady_ocount", ocount, 1);
    next_rdy = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      #1;
      check("t5_ocount", ocount, (k < 63) ? k : 63);
      tick();
    end
    next_rdy = 1'b1;
    repeat (4) tick();

    // 6: async reset mid-stream with a read in flight.
    check("t6_streaming", imem_rd_en, 1);
    #1;
    rst_n = 1'b0;
    rst_pulses++;
    #1;
    check("t6_rst_vld", vld, 0);
    check("t6_rst_rd_en", imem_rd_en, 0);
    check("t6_rst_pc_en", PC_en, 0);
    check("t6_rst_instr", instr_out, 0);
    check("t6_rst_ocount", ocount, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("t6_late_dropped", vld, 0);
    check("t6_rd_en", imem_rd_en, 1);
    check("t6_addr0", imem_addr, 0);
    tick();
    check("t6_vld_c1", vld, 0);
    tick();
    check("t6_vld_c2", vld, 1);
    check("t6_instr0", instr_out, 0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
